mdu_sequencer: RTL and testbench

Multiply/divide unit with its own sequencer for the E stage of the five-stage pipeline. It accepts one `mult`/`multu`/`div`/`divu`/`mthi`/`mtlo` per issue, models the architected multi-cycle latency with a busy counter, and owns the HI/LO registers. It drives the stall request that holds the D stage while an MD-class instruction would collide with an in-flight operation, and returns HI/LO for `mfhi`/`mflo`.

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mdu_sequencer_busy_counter.sv | 26 ++
 rtl/mdu_sequencer.sv | 157 +++++++++++++++
 tb/tb_mdu_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and default latencies for the multiply/divide sequencer.
// The MD_MADD encoding only decodes when the top is built with MDU_MADD_EN.
package mdu_pkg;

  localparam int CNT_W           = 4;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8,
    MD_MADD  = 4'd9
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/mdu_sequencer_busy_counter.sv
// Down-counter that models the multi-cycle latency; done marks the last busy cycle.
module md_busy_counter
  import mdu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign done = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/mdu_sequencer.sv
// Multiply/divide unit for the E stage: owns HI/LO, models latency, raises the D-stage stall.
// Optional feature: define MDU_MADD_EN to enable MD_MADD ({HI,LO} += signed A*B).
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MD_Op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_isMD,
  output logic        busy,
  output logic        stall_MD,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MD_Out
);

  localparam logic [CNT_W-1:0] MULT_CNT = MULT_CYCLES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] DIV_CNT  = DIV_CYCLES[CNT_W-1:0];

  md_state_e        state_reg, state_next;
  md_op_e           op_dec;
  logic             is_muldiv, is_div;
  logic             issue, commit, cnt_done;
  logic [CNT_W-1:0] lat_sel;

  logic [31:0] hi_reg, lo_reg;
  logic [31:0] hi_nxt, lo_nxt;
  logic        div_zero_reg;

  logic [31:0]        div_b;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] quo_s, rem_s;
  logic [31:0]        quo_u, rem_u;
  logic [63:0]        result;

  // Unknown encodings (and MD_MADD when not built in) behave as no issue.
  always_comb begin
    op_dec = MD_NONE;
    case (E_MD_Op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
      MD_MTHI, MD_MTLO, MD_MFHI, MD_MFLO: op_dec = md_op_e'(E_MD_Op);
`ifdef MDU_MADD_EN
      MD_MADD: op_dec = MD_MADD;
`endif
      default: op_dec = MD_NONE;
    endcase
  end

  always_comb begin
    is_div    = (op_dec == MD_DIV) || (op_dec == MD_DIVU);
    is_muldiv = is_div || (op_dec == MD_MULT) || (op_dec == MD_MULTU);
`ifdef MDU_MADD_EN
    is_muldiv = is_muldiv || (op_dec == MD_MADD);
`endif
    lat_sel = is_div ? DIV_CNT : MULT_CNT;
  end

  // Divisor forced to 1 on zero so the dividers never see x; that result is discarded.
  assign div_b  = (E_B == 32'd0) ? 32'd1 : E_B;
  assign prod_s = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
  assign prod_u = {32'd0, E_A} * {32'd0, E_B};
  assign quo_s  = $signed(E_A) / $signed(div_b);
  assign rem_s  = $signed(E_A) % $signed(div_b);
  assign quo_u  = E_A / div_b;
  assign rem_u  = E_A % div_b;

  always_comb begin
    result = 64'd0;
    case (op_dec)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = {rem_s, quo_s};
      MD_DIVU:  result = {rem_u, quo_u};
`ifdef MDU_MADD_EN
      MD_MADD:  result = {hi_reg, lo_reg} + prod_s;
`endif
      default:  result = 64'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (is_muldiv) begin
          issue      = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt_done) begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  md_busy_counter u_busy_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (issue),
    .load_val (lat_sel),
    .done     (cnt_done)
  );

  // Anything presented while RUN is ignored, including mthi/mtlo.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_reg       <= 32'd0;
      lo_reg       <= 32'd0;
      hi_nxt       <= 32'd0;
      lo_nxt       <= 32'd0;
      div_zero_reg <= 1'b0;
    end else begin
      if (issue) begin
        hi_nxt       <= result[63:32];
        lo_nxt       <= result[31:0];
        div_zero_reg <= is_div && (E_B == 32'd0);
      end
      if (commit && !div_zero_reg) begin
        hi_reg <= hi_nxt;
        lo_reg <= lo_nxt;
      end
      if (state_reg == IDLE && op_dec == MD_MTHI) begin
        hi_reg <= E_A;
      end
      if (state_reg == IDLE && op_dec == MD_MTLO) begin
        lo_reg <= E_A;
      end
    end
  end

  assign busy     = (state_reg == RUN);
  assign stall_MD = D_isMD && (busy || is_muldiv);
  assign HI       = hi_reg;
  assign LO       = lo_reg;
  assign MD_Out   = (E_MD_Op == MD_MFHI) ? hi_reg : lo_reg;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: expected {HI,LO} queued at issue, compared when busy drops.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_MD_Op;
  logic [31:0] E_A, E_B;
  logic        D_isMD;
  logic        busy, stall_MD;
  logic [31:0] HI, LO, MD_Out;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];
  logic [63:0] model_hilo;

  mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .E_MD_Op  (E_MD_Op),
    .E_A      (E_A),
    .E_B      (E_B),
    .D_isMD   (D_isMD),
    .busy     (busy),
    .stall_MD (stall_MD),
    .HI       (HI),
    .LO       (LO),
    .MD_Out   (MD_Out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a mult/div-class op at the current cycle; returns positioned in the first idle cycle.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat, input bit intrude);
    int n;
    logic [63:0] got;
    sb_q.push_back(exp);
    E_MD_Op = op; E_A = a; E_B = b;
    #1;
    check_val("stall_at_issue", stall_MD, D_isMD);
    check_val("busy_at_issue", busy, 1'b0);
    @(negedge clk);
    E_MD_Op = intrude ? MD_MULT : MD_NONE;
    E_A = 32'h100; E_B = 32'h100;
    #1;
    n = 0;
    while (busy && n < 40) begin
      check_val("stall_while_busy", stall_MD, D_isMD);
      if (n == lat - 1) check_val("no_early_commit", {HI, LO}, model_hilo);
      n++;
      @(negedge clk);
      E_MD_Op = MD_NONE;
      #1;
    end
    check_val("busy_cycles", n, lat);
    check_val("stall_after", stall_MD, 1'b0);
    got = sb_q.pop_front();
    check_val("hilo_result", {HI, LO}, got);
    model_hilo = got;
    $display("op=%0d a=%h b=%h busy=%0d HI=%h LO=%h", op, a, b, n, HI, LO);
  endtask

  task automatic mt_op(input logic [3:0] op, input logic [31:0] val);
    E_MD_Op = op; E_A = val;
    #1;
    check_val("stall_mt", stall_MD, 1'b0);
    @(negedge clk);
    E_MD_Op = MD_NONE;
    #1;
    if (op == MD_MTHI) model_hilo[63:32] = val;
    else               model_hilo[31:0]  = val;
    check_val("busy_mt", busy, 1'b0);
    check_val("hilo_mt", {HI, LO}, model_hilo);
    $display("op=%0d val=%h HI=%h LO=%h", op, val, HI, LO);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] rexp;
    longint sa, sb;
    int q, r;

    reset = 1'b1; E_MD_Op = MD_NONE; E_A = '0; E_B = '0; D_isMD = 1'b1;
    model_hilo = 64'd0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_stall", stall_MD, 1'b0);
    check_val("rst_hilo", {HI, LO}, 64'd0);
    check_val("rst_mdout", MD_Out, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    #1;

    run_op(MD_MULT,  32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, 5, 1'b0);
    run_op(MD_MULTU, 32'hFFFFFFFE, 32'd3, 64'h00000002_FFFFFFFA, 5, 1'b0);
    run_op(MD_DIV,   32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 10, 1'b0);
    run_op(MD_DIVU,  32'd7,        32'd2, 64'h00000001_00000003, 10, 1'b1);

    mt_op(MD_MTHI, 32'h11);
    mt_op(MD_MTLO, 32'h22);
    run_op(MD_DIV, 32'h55, 32'd0, 64'h00000011_00000022, 10, 1'b0);

    mt_op(MD_MTLO, 32'h1234);
    E_MD_Op = MD_MFLO; #1;
    check_val("mflo", MD_Out, 32'h1234);
    E_MD_Op = MD_MFHI; #1;
    check_val("mfhi", MD_Out, 32'h11);
    @(negedge clk);
    E_MD_Op = MD_NONE; #1;
    check_val("mf_no_state", {HI, LO}, 64'h00000011_00001234);
    $display("op=mfhi/mflo HI=%h LO=%h", HI, LO);

    D_isMD = 1'b0;
    run_op(MD_MULT, 32'h10000, 32'h10000, 64'h00000001_00000000, 5, 1'b0);
    D_isMD = 1'b1;

    E_MD_Op = 4'hF; E_A = 32'h5; E_B = 32'h6; #1;
    check_val("illegal_stall", stall_MD, 1'b0);
    @(negedge clk); E_MD_Op = MD_NONE; #1;
    check_val("illegal_busy", busy, 1'b0);
    check_val("illegal_hilo", {HI, LO}, model_hilo);
`ifdef MDU_MADD_EN
    run_op(MD_MADD, 32'hFFFFFFFE, 32'd3, model_hilo + 64'hFFFFFFFF_FFFFFFFA, 5, 1'b0);
`else
    E_MD_Op = MD_MADD; E_A = 32'h5; E_B = 32'h6; #1;
    @(negedge clk); E_MD_Op = MD_NONE; #1;
    check_val("madd_off_busy", busy, 1'b0);
    check_val("madd_off_hilo", {HI, LO}, model_hilo);
`endif

    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom;
      if (rb == 32'd0) rb = 32'd9;
      case (i % 4)
        0: begin
          sa = $signed(ra); sb = $signed(rb);
          rexp = sa * sb;
          run_op(MD_MULT, ra, rb, rexp, 5, 1'b0);
        end
        1: begin
          rexp = {32'd0, ra} * {32'd0, rb};
          run_op(MD_MULTU, ra, rb, rexp, 5, 1'b0);
        end
        2: begin
          if (rb == 32'hFFFFFFFF) ra[31] = 1'b0;
          q = $signed(ra) / $signed(rb);
          r = $signed(ra) % $signed(rb);
          rexp = {r, q};
          run_op(MD_DIV, ra, rb, rexp, 10, 1'b0);
        end
        default: begin
          rb = rb >> (i * 3);
          if (rb == 32'd0) rb = 32'd3;
          rexp = {ra % rb, ra / rb};
          run_op(MD_DIVU, ra, rb, rexp, 10, 1'b0);
        end
      endcase
    end

    // Abort a mult in its third busy cycle.
    E_MD_Op = MD_MULT; E_A = 32'd5; E_B = 32'd7;
    @(negedge clk); E_MD_Op = MD_NONE;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_hilo", {HI, LO}, 64'd0);
    reset = 1'b0;
    model_hilo = 64'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check_val("abort_idle", busy, 1'b0);
    end
    check_val("abort_no_commit", {HI, LO}, 64'd0);
    $display("op=reset_abort HI=%h LO=%h", HI, LO);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
